ripple_add_sequencer: RTL and testbench

- Multi-cycle wide add/subtract controller built around one shared N-bit ripple-carry chunk adder.
- Captures W = N*CHUNKS-bit operands with a valid/ready handshake, then steps the chunk adder over the operand slices one slice per clock, LSB slice first, registering the carry between slices.
- Presents the full-width result, carry and signed overflow with a valid/ready handshake.
- Sits between operand producers and result consumers wherever a full-width adder is too costly in area.

---
 rtl/ripple_add_sequencer.sv | 162 ++++++++++++++++
 tb/tb_ripple_add_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_add_sequencer.sv
// Multi-cycle W = N*CHUNKS bit add/subtract built on one shared N-bit ripple-carry adder.
// Operands are captured with a valid/ready handshake and processed one slice per clock, LSB slice first.

module ripple_chunk_adder #(
   parameter int N = 4
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         c_i,
   output logic [N-1:0] sum_o,
   output logic         c_o,
   output logic         c_msb_o
);
   logic [N:0] c;

   assign c[0] = c_i;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

   assign c_o     = c[N];
   // Carry into the top bit of the chunk; only meaningful for the top slice's overflow.
   assign c_msb_o = c[N-1];
endmodule

module ripple_add_sequencer #(
   parameter int N      = 4,
   parameter int CHUNKS = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [N*CHUNKS-1:0]   a_i,
   input  logic [N*CHUNKS-1:0]   b_i,
   input  logic                  sub_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [N*CHUNKS-1:0]   result_o,
   output logic                  carry_out_o,
   output logic                  overflow_o
);
   localparam int W  = N * CHUNKS;
   localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   localparam logic [IW-1:0] IDX_LAST = IW'(CHUNKS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic          carry_q, carry_d;
   logic [W-1:0]  result_q, result_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;

   logic [N-1:0]  sl_a;
   logic [N-1:0]  sl_b;
   logic [N-1:0]  chunk_sum;
   logic          chunk_c;
   logic          chunk_cmsb;

   always_comb begin
      sl_a = '0;
      sl_b = '0;
      for (int s = 0; s < CHUNKS; s++) begin
         if (idx_q == IW'(s)) begin
            sl_a = a_q[s*N +: N];
            sl_b = b_q[s*N +: N];
         end
      end
   end

   ripple_chunk_adder #(.N(N)) u_chunk (
      .a_i     (sl_a),
      .b_i     (sl_b),
      .c_i     (carry_q),
      .sum_o   (chunk_sum),
      .c_o     (chunk_c),
      .c_msb_o (chunk_cmsb)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               // Subtraction is folded into the add: B is inverted here and the +1 rides in as carry-in.
               a_d     = a_i;
               b_d     = sub_i ? ~b_i : b_i;
               carry_d = sub_i;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            for (int s = 0; s < CHUNKS; s++) begin
               if (idx_q == IW'(s)) begin
                  result_d[s*N +: N] = chunk_sum;
               end
            end
            carry_d = chunk_c;
            if (idx_q == IDX_LAST) begin
               cout_d  = chunk_c;
               ovf_d   = chunk_c ^ chunk_cmsb;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         S_DONE: begin
            if (out_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready_o  = (state_q == S_IDLE);
   assign out_valid_o = (state_q == S_DONE);
   assign result_o    = result_q;
   assign carry_out_o = cout_q;
   assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Self-checking bench for ripple_add_sequencer (N=4, CHUNKS=4) using a queue scoreboard.
module tb_ripple_add_sequencer;
   localparam int N      = 4;
   localparam int CHUNKS = 4;
   localparam int W      = N * CHUNKS;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct packed {
      logic [W-1:0] r;
      logic         c;
      logic         v;
   } exp_t;

   exp_t sb_q[$];

   ripple_add_sequencer #(.N(N), .CHUNKS(CHUNKS)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a),
      .b_i         (b),
      .sub_i       (sub),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .result_o    (result),
      .carry_out_o (carry_out),
      .overflow_o  (overflow)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      logic [W:0]   full;
      logic [W-1:0] yy;
      exp_t         e;
      yy   = s ? ~y : y;
      full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
      e.r  = full[W-1:0];
      e.c  = full[W];
      if (s) e.v = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
      else   e.v = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
      return e;
   endfunction

   // Drive one operation from IDLE and wait for out_valid; edges counts from the capture edge.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         output int edges, output logic timed_out);
      @(negedge clk);
      a = x; b = y; sub = s; in_valid = 1'b1;
      sb_q.push_back(model(x, y, s));
      edges = 0;
      timed_out = 1'b0;
      while (1) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         in_valid = 1'b0;
         if (out_valid) break;
         if (edges >= 40) begin
            timed_out = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({in_ready, out_valid, result, carry_out, overflow} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_state: rdy=%b vld=%b res=%h c=%b v=%b, want rdy=1 vld=0 res=0000 c=0 v=0",
                  in_ready, out_valid, result, carry_out, overflow);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [W-1:0] ta [6] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'hA5A5};
      logic [W-1:0] tb [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h5A5B};
      logic         ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      int   edges;
      logic to;
      exp_t e;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         run_op(ta[i], tb[i], ts[i], edges, to);
         e = sb_q.pop_front();
         tests_run++;
         if (to) begin
            tests_failed++;
            $display("FAIL basic_timeout[%0d]: out_valid=%b after %0d edges, want 1", i, out_valid, edges);
            continue;
         end
         tests_run++;
         if (edges != CHUNKS + 1) begin
            tests_failed++;
            $display("FAIL basic_latency[%0d]: %0d edges, want %0d", i, edges, CHUNKS + 1);
         end
         tests_run++;
         if ({result, carry_out, overflow} !== {e.r, e.c, e.v}) begin
            tests_failed++;
            $display("FAIL basic_result[%0d]: res=%h c=%b v=%b, want res=%h c=%b v=%b",
                     i, result, carry_out, overflow, e.r, e.c, e.v);
         end
         @(posedge clk);
         @(negedge clk);
         tests_run++;
         if ({out_valid, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL basic_release[%0d]: vld=%b rdy=%b, want vld=0 rdy=1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   n;
      out_ready = 1'b0;
      @(negedge clk);
      a = 16'h00FF; b = 16'h0001; sub = 1'b0; in_valid = 1'b1;
      sb_q.push_back(model(16'h00FF, 16'h0001, 1'b0));
      @(posedge clk);
      n = 0;
      // Pulse in_valid with foreign operands through RUN until DONE appears.
      while (1) begin
         @(negedge clk);
         if (out_valid || n >= 20) break;
         a = 16'h1234; b = 16'h1111; in_valid = ~in_valid;
         tests_run++;
         if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_run_ready: rdy=%b, want 0", in_ready);
         end
         @(posedge clk);
         n++;
      end
      e = sb_q.pop_front();
      tests_run++;
      if (out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_timeout: out_valid=%b, want 1", out_valid);
      end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if ({out_valid, in_ready, result, carry_out, overflow} !== {1'b1, 1'b0, e.r, e.c, e.v}) begin
            tests_failed++;
            $display("FAIL bp_hold[%0d]: vld=%b rdy=%b res=%h c=%b v=%b, want vld=1 rdy=0 res=%h c=%b v=%b",
                     i, out_valid, in_ready, result, carry_out, overflow, e.r, e.c, e.v);
         end
         a = 16'h1234; in_valid = (i < 3);
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({out_valid, in_ready} !== 2'b01) begin
         tests_failed++;
         $display("FAIL bp_release: vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         tests_run++;
         if ({out_valid, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL bp_no_capture[%0d]: vld=%b rdy=%b, want vld=0 rdy=1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_reset_midrun();
      int   edges;
      logic to;
      exp_t e;
      out_ready = 1'b1;
      run_op(16'h8000, 16'h0001, 1'b1, edges, to);
      e = sb_q.pop_front();
      tests_run++;
      if ({to, result, carry_out, overflow} !== {1'b0, e.r, e.c, e.v}) begin
         tests_failed++;
         $display("FAIL rst_pre_op: to=%b res=%h c=%b v=%b, want to=0 res=%h c=%b v=%b",
                  to, result, carry_out, overflow, e.r, e.c, e.v);
      end
      @(posedge clk);
      @(negedge clk);
      a = 16'h00FF; b = 16'h0001; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if ({in_ready, out_valid, result, carry_out, overflow} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL rst_midrun: rdy=%b vld=%b res=%h c=%b v=%b, want rdy=1 vld=0 res=0000 c=0 v=0",
                  in_ready, out_valid, result, carry_out, overflow);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         tests_run++;
         if ({out_valid, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL rst_discard[%0d]: vld=%b rdy=%b, want vld=0 rdy=1", i, out_valid, in_ready);
         end
      end
      run_op(16'h0003, 16'h0004, 1'b0, edges, to);
      e = sb_q.pop_front();
      tests_run++;
      if ({to, edges, result, carry_out, overflow} !== {1'b0, CHUNKS + 1, 16'h0007, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL rst_next_op: to=%b edges=%0d res=%h c=%b v=%b, want to=0 edges=%0d res=0007 c=0 v=0",
                  to, edges, result, carry_out, overflow, CHUNKS + 1);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int acc_cyc[$];
      int k = 0;
      int pops = 0;
      exp_t e;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 80 && pops < 4; cyc++) begin
         @(negedge clk);
         a = 16'h1111 * (k + 1); b = 16'h0F0F + k; sub = k[0]; in_valid = (k < 4);
         if (in_valid && in_ready) begin
            sb_q.push_back(model(a, b, sub));
            acc_cyc.push_back(cyc);
            k++;
         end
         if (out_valid && out_ready) begin
            e = sb_q.pop_front();
            pops++;
            tests_run++;
            if ({result, carry_out, overflow} !== {e.r, e.c, e.v}) begin
               tests_failed++;
               $display("FAIL b2b_result[%0d]: res=%h c=%b v=%b, want res=%h c=%b v=%b",
                        pops, result, carry_out, overflow, e.r, e.c, e.v);
            end
         end
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      tests_run++;
      if (pops != 4 || acc_cyc.size() != 4) begin
         tests_failed++;
         $display("FAIL b2b_count: pops=%0d accepts=%0d, want 4 and 4", pops, acc_cyc.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            tests_run++;
            if (acc_cyc[i] - acc_cyc[i-1] != CHUNKS + 2) begin
               tests_failed++;
               $display("FAIL b2b_interval[%0d]: %0d cycles, want %0d", i, acc_cyc[i] - acc_cyc[i-1], CHUNKS + 2);
            end
         end
      end
      sb_q.delete();
   endtask

   task automatic test_random();
      int   issued = 0;
      int   pops = 0;
      exp_t e;
      for (int cyc = 0; cyc < 2000 && pops < 16; cyc++) begin
         @(negedge clk);
         if (in_ready || !in_valid) begin
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
         end
         in_valid  = (issued < 16) && ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         if (in_valid && in_ready) begin
            sb_q.push_back(model(a, b, sub));
            issued++;
         end
         if (out_valid && out_ready) begin
            e = sb_q.pop_front();
            pops++;
            tests_run++;
            if ({result, carry_out, overflow} !== {e.r, e.c, e.v}) begin
               tests_failed++;
               $display("FAIL rand_result[%0d]: res=%h c=%b v=%b, want res=%h c=%b v=%b",
                        pops, result, carry_out, overflow, e.r, e.c, e.v);
            end
         end
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      tests_run++;
      if (pops != 16 || sb_q.size() != 0) begin
         tests_failed++;
         $display("FAIL rand_drain: pops=%0d left=%0d, want 16 and 0", pops, sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_reset_midrun();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
